// File: rtl/axi_pkg.sv
// Shared types and constants for the AXI-lite memory arbiter: FSM states,
// grant identifiers and AXI response codes.
package axi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        IFU_RD = 2'd1,
        LSU_RD = 2'd2,
        LSU_WR = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IFU = 1'b0,
        GNT_LSU = 1'b1
    } grant_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; bit 0 is the IFU, bit 1 the LSU.
// Purely combinational, the previous winner is remembered by the parent.
module rr_arb2
    import axi_pkg::*;
(
    input  logic [1:0] req,
    input  grant_t     last_grant,
    output logic [1:0] gnt,
    output logic       gnt_valid
);

    always_comb begin
        gnt       = 2'b00;
        gnt_valid = |req;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            // On a tie, the requester that did not win last time goes first
            2'b11:   gnt = (last_grant == GNT_LSU) ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi_lite_mem_arbiter.sv
// Shares one AXI-lite SRAM master port between the IFU (read-only) and the
// LSU (read/write); one transaction in flight, grant held until its response.
module axi_lite_mem_arbiter
    import axi_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [ADDR_WIDTH-1:0]   IFU_AR_ADDR,
    input  logic                    IFU_AR_VALID,
    output logic                    IFU_AR_READY,
    output logic [DATA_WIDTH-1:0]   IFU_R_DATA,
    output logic [1:0]              IFU_R_RESP,
    output logic                    IFU_R_VALID,
    input  logic                    IFU_R_READY,
    input  logic [ADDR_WIDTH-1:0]   LSU_AR_ADDR,
    input  logic                    LSU_AR_VALID,
    output logic                    LSU_AR_READY,
    output logic [DATA_WIDTH-1:0]   LSU_R_DATA,
    output logic [1:0]              LSU_R_RESP,
    output logic                    LSU_R_VALID,
    input  logic                    LSU_R_READY,
    input  logic [ADDR_WIDTH-1:0]   LSU_AW_ADDR,
    input  logic                    LSU_AW_VALID,
    output logic                    LSU_AW_READY,
    input  logic [DATA_WIDTH-1:0]   LSU_W_DATA,
    input  logic [DATA_WIDTH/8-1:0] LSU_W_STRB,
    input  logic                    LSU_W_VALID,
    output logic                    LSU_W_READY,
    output logic [1:0]              LSU_B_RESP,
    output logic                    LSU_B_VALID,
    input  logic                    LSU_B_READY,
    output logic [ADDR_WIDTH-1:0]   M_AR_ADDR,
    output logic                    M_AR_VALID,
    input  logic                    M_AR_READY,
    input  logic [DATA_WIDTH-1:0]   M_R_DATA,
    input  logic [1:0]              M_R_RESP,
    input  logic                    M_R_VALID,
    output logic                    M_R_READY,
    output logic [ADDR_WIDTH-1:0]   M_AW_ADDR,
    output logic                    M_AW_VALID,
    input  logic                    M_AW_READY,
    output logic [DATA_WIDTH-1:0]   M_W_DATA,
    output logic [DATA_WIDTH/8-1:0] M_W_STRB,
    output logic                    M_W_VALID,
    input  logic                    M_W_READY,
    input  logic [1:0]              M_B_RESP,
    input  logic                    M_B_VALID,
    output logic                    M_B_READY
);

    arb_state_t state_q, state_d;
    grant_t     last_grant_q, last_grant_d;
    logic       ar_done_q, ar_done_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;
    logic [1:0] req;
    logic [1:0] gnt;
    logic       gnt_valid;
    logic       lsu_wr_req;

    assign lsu_wr_req = LSU_AW_VALID | LSU_W_VALID;
    assign req        = {lsu_wr_req | LSU_AR_VALID, IFU_AR_VALID};

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt        (gnt),
        .gnt_valid  (gnt_valid)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_LSU;
            ar_done_q    <= 1'b0;
            aw_done_q    <= 1'b0;
            w_done_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ar_done_q    <= ar_done_d;
            aw_done_q    <= aw_done_d;
            w_done_q     <= w_done_d;
        end
    end

    // Handshakes are taken from the gated downstream outputs, so a channel
    // that is already done can never be counted twice.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        ar_done_d    = ar_done_q;
        aw_done_d    = aw_done_q;
        w_done_d     = w_done_q;
        case (state_q)
            IDLE: begin
                if (gnt_valid && gnt[0]) begin
                    state_d      = IFU_RD;
                    last_grant_d = GNT_IFU;
                end else if (gnt_valid && gnt[1]) begin
                    state_d      = lsu_wr_req ? LSU_WR : LSU_RD;
                    last_grant_d = GNT_LSU;
                end
            end
            IFU_RD, LSU_RD: begin
                if (M_AR_VALID && M_AR_READY) ar_done_d = 1'b1;
                if (M_R_VALID && M_R_READY) begin
                    state_d   = IDLE;
                    ar_done_d = 1'b0;
                end
            end
            LSU_WR: begin
                if (M_AW_VALID && M_AW_READY) aw_done_d = 1'b1;
                if (M_W_VALID && M_W_READY)   w_done_d  = 1'b1;
                if (M_B_VALID && M_B_READY) begin
                    state_d   = IDLE;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        IFU_AR_READY = 1'b0;
        IFU_R_DATA   = '0;
        IFU_R_RESP   = 2'b00;
        IFU_R_VALID  = 1'b0;
        LSU_AR_READY = 1'b0;
        LSU_R_DATA   = '0;
        LSU_R_RESP   = 2'b00;
        LSU_R_VALID  = 1'b0;
        LSU_AW_READY = 1'b0;
        LSU_W_READY  = 1'b0;
        LSU_B_RESP   = 2'b00;
        LSU_B_VALID  = 1'b0;
        M_AR_ADDR    = '0;
        M_AR_VALID   = 1'b0;
        M_R_READY    = 1'b0;
        M_AW_ADDR    = '0;
        M_AW_VALID   = 1'b0;
        M_W_DATA     = '0;
        M_W_STRB     = '0;
        M_W_VALID    = 1'b0;
        M_B_READY    = 1'b0;
        case (state_q)
            IFU_RD: begin
                M_AR_ADDR    = IFU_AR_ADDR;
                M_AR_VALID   = IFU_AR_VALID & ~ar_done_q;
                IFU_AR_READY = M_AR_READY & ~ar_done_q;
                IFU_R_DATA   = M_R_DATA;
                IFU_R_RESP   = M_R_RESP;
                IFU_R_VALID  = M_R_VALID;
                M_R_READY    = IFU_R_READY;
            end
            LSU_RD: begin
                M_AR_ADDR    = LSU_AR_ADDR;
                M_AR_VALID   = LSU_AR_VALID & ~ar_done_q;
                LSU_AR_READY = M_AR_READY & ~ar_done_q;
                LSU_R_DATA   = M_R_DATA;
                LSU_R_RESP   = M_R_RESP;
                LSU_R_VALID  = M_R_VALID;
                M_R_READY    = LSU_R_READY;
            end
            LSU_WR: begin
                M_AW_ADDR    = LSU_AW_ADDR;
                M_AW_VALID   = LSU_AW_VALID & ~aw_done_q;
                LSU_AW_READY = M_AW_READY & ~aw_done_q;
                M_W_DATA     = LSU_W_DATA;
                M_W_STRB     = LSU_W_STRB;
                M_W_VALID    = LSU_W_VALID & ~w_done_q;
                LSU_W_READY  = M_W_READY & ~w_done_q;
                LSU_B_RESP   = M_B_RESP;
                LSU_B_VALID  = M_B_VALID;
                M_B_READY    = LSU_B_READY;
            end
            default: ;
        endcase
    end

endmodule
